csrng_state_store: RTL and testbench
====================================

Name: csrng_state_store

Overview:
- Parametrised successor to the CSRNG per-instance DRBG working-state container.
- Holds fips, inst_st, key, V and reseed counter for NApps instances, with a combinational read port and a ready/valid write port that returns a registered status ack.
- Adds a zeroization sweep FSM, out-of-range ID detection, UNI-command zeroize and a generic RegW-wide diagnostic dump with wrap and last flag.
- Sits between csrng_main_sm/cmd stages and the register block.

Parameters:
- NApps, 4, number of DRBG instances.
- StateId, 4, instance ID width; 2**StateId >= NApps.
- BlkLen, 128, V width.
- KeyLen, 256, key width.
- CtrLen, 32, reseed counter width.
- Cmd, 3, command opcode width (csrng_pkg acmd encoding).
- RegW, 32, diagnostic word width.
- Derived: StW = 2+KeyLen+BlkLen+CtrLen (418); NumWords = ceil(StW/RegW) (14); PtrW = clog2(NumWords).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- enable_i  in  1  block enable; falling edge triggers zeroize sweep
- rd_inst_id_i  in  StateId  read instance select
- rd_key_o / rd_v_o / rd_ctr_o  out  KeyLen / BlkLen / CtrLen  selected state fields
- rd_inst_st_o, rd_fips_o  out  1  selected instantiated / fips flags
- rd_id_err_o  out  1  rd_inst_id_i >= NApps
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  write accepted when high
- wr_inst_id_i  in  StateId  target instance
- wr_fips_i  in  1  fips flag
- wr_ccmd_i  in  Cmd  command that produced the state
- wr_key_i / wr_v_i / wr_ctr_i  in  KeyLen / BlkLen / CtrLen  new state
- wr_sts_i  in  csrng_cmd_sts_e  command status to echo
- sts_ack_o  out  1  one-cycle ack pulse
- sts_o  out  csrng_cmd_sts_e  echoed or overridden status
- sts_id_o  out  StateId  acked instance
- dump_en_i  in  1  diagnostic dump enable
- dump_id_valid_i  in  1  pulse: load dump_id_i and rewind pointer
- dump_id_i  in  StateId  instance to dump
- dump_rd_i  in  1  advance dump pointer
- read_enable_i  in  NApps  per-instance dump permission
- dump_data_o  out  RegW  current diagnostic word
- dump_last_o  out  1  pointer at final word
- reseed_counter_o  out  NApps x CtrLen  per-instance counters, always visible

Behaviour:
- Reset (rst_i high at clk_i edge):
  - all instance states = 0;
  - sts_ack_o = 0, sts_o = CMD_STS_SUCCESS, sts_id_o = 0;
  - dump pointer = 0, dump ID = 0;
  - FSM = CLEAR, sweep idx = 0.
- FSM states: CLEAR, IDLE, ACTIVE.
  - CLEAR: zeroes instance[idx], idx++ each cycle. At idx == NApps-1, go to ACTIVE if enable_i else IDLE. Sweep is never aborted by enable_i.
  - IDLE: go to ACTIVE when enable_i = 1.
  - ACTIVE: go to CLEAR (idx = 0) when enable_i = 0.
- wr_ready_o = (FSM == ACTIVE). Handshake = wr_valid_i && wr_ready_o.
- Write, on handshake:
  - id < NApps: instance[id] <= {wr_fips_i, inst_st, key, V, ctr}.
  - inst_st = 1 for INS/RES/GENU/UPD; otherwise 0.
  - ccmd == UNI: key, V, ctr and fips are also forced to 0.
  - id >= NApps: no state change; sts overridden to CMD_STS_INVALID_CMD_SEQ.
- Ack: sts_ack_o pulses exactly 1 cycle after handshake, with sts_o/sts_id_o registered from that cycle. Otherwise sts_ack_o = 0 and sts_o/sts_id_o hold. Back-to-back writes give back-to-back acks.
- Read port:
  - combinational from stored state; a same-cycle write is visible next cycle;
  - id >= NApps: all fields 0 and rd_id_err_o = 1.
- reseed_counter_o[i] = ctr field of instance i at all times (0 during and after sweep).
- Dump:
  - image = zero-extend(instance[dump_id]) to NumWords*RegW; word k = bits [(k+1)*RegW-1 : k*RegW].
  - dump_data_o = word[ptr] when dump_en_i, FSM == ACTIVE, dump_id < NApps and read_enable_i[dump_id]; else 0.
  - Pointer priority: !dump_en_i -> 0; dump_id_valid_i -> 0 and load ID; dump_rd_i -> ptr+1, wrapping from NumWords-1 to 0; else hold.
  - dump_id_valid_i beats a simultaneous dump_rd_i.
  - dump_last_o = (ptr == NumWords-1) && dump_en_i.
  - Dump ID clears to 0 when FSM leaves ACTIVE.

Test Plan:
- Reset, then enable_i = 1: wr_ready_o low for 4 cycles (CLEAR), then high; every reseed_counter_o = 0; sts_ack_o = 0.
- Write id 2, ccmd = INS, key = {8{32'hA5A5A5A5}}, ctr = 5 -> ack next cycle with sts_id_o = 2, sts_o = wr_sts_i; rd id 2 returns inst_st = 1, ctr = 5; reseed_counter_o[2] = 5.
- Write id 2 with ccmd = UNI -> rd id 2 returns all zeros including inst_st; write id 7 -> sts_o = CMD_STS_INVALID_CMD_SEQ, no state change; rd id 7 gives rd_id_err_o = 1.
- Dump id 2 with read_enable_i[2] = 1: 14 dump_rd_i pulses cycle words 0..13 then wrap to 0; dump_last_o high only at ptr 13; word 13 upper 30 bits = 0. With read_enable_i[2] = 0, dump_data_o = 0.
- Drop enable_i mid-write stream: wr_ready_o low next cycle; all instances zero after 4 sweep cycles; re-raise enable_i during the sweep -> ACTIVE only after idx 3.
- Assert rst_i during CLEAR at idx 1 -> sweep restarts at idx 0; sts_o = CMD_STS_SUCCESS.

Source files
------------

// File: rtl/csrng_state_store.sv
// rtl/csrng_state_store.sv - per-instance CSRNG DRBG working-state store with zeroize sweep and diagnostic dump

package csrng_state_store_pkg;
    typedef enum logic [2:0] {
        CMD_STS_SUCCESS         = 3'h0,
        CMD_STS_INVALID_ACMD    = 3'h1,
        CMD_STS_INVALID_GEN_CMD = 3'h2,
        CMD_STS_INVALID_CMD_SEQ = 3'h3,
        CMD_STS_RESERVED_ID     = 3'h4
    } csrng_cmd_sts_e;
endpackage

module csrng_state_store
    import csrng_state_store_pkg::*;
#(
    parameter int NApps   = 4,
    parameter int StateId = 4,
    parameter int BlkLen  = 128,
    parameter int KeyLen  = 256,
    parameter int CtrLen  = 32,
    parameter int Cmd     = 3,
    parameter int RegW    = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           enable_i,
    input  logic [StateId-1:0]             rd_inst_id_i,
    output logic [KeyLen-1:0]              rd_key_o,
    output logic [BlkLen-1:0]              rd_v_o,
    output logic [CtrLen-1:0]              rd_ctr_o,
    output logic                           rd_inst_st_o,
    output logic                           rd_fips_o,
    output logic                           rd_id_err_o,
    input  logic                           wr_valid_i,
    output logic                           wr_ready_o,
    input  logic [StateId-1:0]             wr_inst_id_i,
    input  logic                           wr_fips_i,
    input  logic [Cmd-1:0]                 wr_ccmd_i,
    input  logic [KeyLen-1:0]              wr_key_i,
    input  logic [BlkLen-1:0]              wr_v_i,
    input  logic [CtrLen-1:0]              wr_ctr_i,
    input  csrng_cmd_sts_e                 wr_sts_i,
    output logic                           sts_ack_o,
    output csrng_cmd_sts_e                 sts_o,
    output logic [StateId-1:0]             sts_id_o,
    input  logic                           dump_en_i,
    input  logic                           dump_id_valid_i,
    input  logic [StateId-1:0]             dump_id_i,
    input  logic                           dump_rd_i,
    input  logic [NApps-1:0]               read_enable_i,
    output logic [RegW-1:0]                dump_data_o,
    output logic                           dump_last_o,
    output logic [NApps-1:0][CtrLen-1:0]   reseed_counter_o
);

    // Packed instance layout, MSB first: {fips, inst_st, key, V, ctr}.
    localparam int StW       = 2 + KeyLen + BlkLen + CtrLen;
    localparam int NumWords  = (StW + RegW - 1) / RegW;
    localparam int PtrW      = (NumWords > 1) ? $clog2(NumWords) : 1;
    localparam int IdxW      = (NApps > 1) ? $clog2(NApps) : 1;
    localparam int ImgW      = NumWords * RegW;
    localparam int VLsb      = CtrLen;
    localparam int KeyLsb    = CtrLen + BlkLen;
    localparam int InstStBit = StW - 2;
    localparam int FipsBit   = StW - 1;

    localparam logic [StateId:0]   NAppsLim = (StateId + 1)'(NApps);
    localparam logic [IdxW-1:0]    LastIdx  = IdxW'(NApps - 1);
    localparam logic [PtrW-1:0]    LastPtr  = PtrW'(NumWords - 1);

    // Application command opcodes.
    localparam logic [Cmd-1:0] AcmdIns  = Cmd'(1);
    localparam logic [Cmd-1:0] AcmdRes  = Cmd'(2);
    localparam logic [Cmd-1:0] AcmdUpd  = Cmd'(4);
    localparam logic [Cmd-1:0] AcmdUni  = Cmd'(5);
    localparam logic [Cmd-1:0] AcmdGenu = Cmd'(7);

    typedef enum logic [1:0] {
        StClear,
        StIdle,
        StActive
    } fsm_e;

    fsm_e              fsm_q, fsm_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [StW-1:0]    state_q [NApps];

    logic              wr_hs;
    logic              wr_id_ok;
    logic              wr_inst_st;
    logic [StW-1:0]    wr_state;

    logic              rd_id_ok;
    logic [StW-1:0]    rd_state;

    logic [StateId-1:0] dump_id_q;
    logic [PtrW-1:0]    dump_ptr_q;
    logic               dump_id_ok;
    logic [StW-1:0]     dump_state;
    logic [ImgW-1:0]    dump_img;
    logic               dump_allow;

    // Sweep state and index register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fsm_q <= StClear;
            idx_q <= '0;
        end else begin
            fsm_q <= fsm_d;
            idx_q <= idx_d;
        end
    end

    // Next-state: a started sweep always runs to the last instance before enable_i is honoured.
    always_comb begin
        fsm_d = fsm_q;
        idx_d = idx_q;
        case (fsm_q)
            StClear: begin
                if (idx_q == LastIdx) begin
                    idx_d = '0;
                    fsm_d = enable_i ? StActive : StIdle;
                end else begin
                    idx_d = idx_q + IdxW'(1);
                end
            end
            StIdle: begin
                if (enable_i) begin
                    fsm_d = StActive;
                end
            end
            StActive: begin
                if (!enable_i) begin
                    fsm_d = StClear;
                    idx_d = '0;
                end
            end
            default: begin
                fsm_d = StClear;
                idx_d = '0;
            end
        endcase
    end

    assign wr_ready_o = (fsm_q == StActive);
    assign wr_hs      = wr_valid_i && wr_ready_o;
    assign wr_id_ok   = ({1'b0, wr_inst_id_i} < NAppsLim);

    // Build the state to store; uninstantiate wipes the whole record.
    always_comb begin
        wr_inst_st = (wr_ccmd_i == AcmdIns) || (wr_ccmd_i == AcmdRes) ||
                     (wr_ccmd_i == AcmdGenu) || (wr_ccmd_i == AcmdUpd);
        wr_state   = {wr_fips_i, wr_inst_st, wr_key_i, wr_v_i, wr_ctr_i};
        if (wr_ccmd_i == AcmdUni) begin
            wr_state = '0;
        end
    end

    // Instance storage: sweep zeroing and handshake writes never coincide (CLEAR vs ACTIVE).
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NApps; i++) begin
                state_q[i] <= '0;
            end
        end else if (fsm_q == StClear) begin
            state_q[idx_q] <= '0;
        end else if (wr_hs && wr_id_ok) begin
            state_q[wr_inst_id_i[IdxW-1:0]] <= wr_state;
        end
    end

    // Status ack one cycle after each handshake; status and id hold between acks.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sts_ack_o <= 1'b0;
            sts_o     <= CMD_STS_SUCCESS;
            sts_id_o  <= '0;
        end else begin
            sts_ack_o <= wr_hs;
            if (wr_hs) begin
                sts_o    <= wr_id_ok ? wr_sts_i : CMD_STS_INVALID_CMD_SEQ;
                sts_id_o <= wr_inst_id_i;
            end
        end
    end

    assign rd_id_ok     = ({1'b0, rd_inst_id_i} < NAppsLim);
    assign rd_state     = rd_id_ok ? state_q[rd_inst_id_i[IdxW-1:0]] : '0;
    assign rd_id_err_o  = !rd_id_ok;
    assign rd_ctr_o     = rd_state[CtrLen-1:0];
    assign rd_v_o       = rd_state[VLsb +: BlkLen];
    assign rd_key_o     = rd_state[KeyLsb +: KeyLen];
    assign rd_inst_st_o = rd_state[InstStBit];
    assign rd_fips_o    = rd_state[FipsBit];

    // Expose every instance's reseed counter.
    always_comb begin
        reseed_counter_o = '0;
        for (int i = 0; i < NApps; i++) begin
            reseed_counter_o[i] = state_q[i][CtrLen-1:0];
        end
    end

    // Dump pointer and selected instance; the id is dropped whenever the block leaves ACTIVE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            dump_ptr_q <= '0;
            dump_id_q  <= '0;
        end else begin
            if (!dump_en_i) begin
                dump_ptr_q <= '0;
            end else if (dump_id_valid_i) begin
                dump_ptr_q <= '0;
            end else if (dump_rd_i) begin
                dump_ptr_q <= (dump_ptr_q == LastPtr) ? '0 : dump_ptr_q + PtrW'(1);
            end

            if ((fsm_q == StActive) && (fsm_d != StActive)) begin
                dump_id_q <= '0;
            end else if (dump_en_i && dump_id_valid_i) begin
                dump_id_q <= dump_id_i;
            end
        end
    end

    assign dump_id_ok  = ({1'b0, dump_id_q} < NAppsLim);
    assign dump_state  = dump_id_ok ? state_q[dump_id_q[IdxW-1:0]] : '0;
    assign dump_img    = ImgW'(dump_state);
    assign dump_allow  = dump_en_i && (fsm_q == StActive) && dump_id_ok &&
                         read_enable_i[dump_id_q[IdxW-1:0]];
    assign dump_data_o = dump_allow ? dump_img[RegW*int'(dump_ptr_q) +: RegW] : '0;
    assign dump_last_o = (dump_ptr_q == LastPtr) && dump_en_i;

endmodule

// File: tb/tb_csrng_state_store.sv
// tb/tb_csrng_state_store.sv - randomized self-checking bench for csrng_state_store
module tb_csrng_state_store;
    import csrng_state_store_pkg::*;

    localparam int NApps    = 4;
    localparam int StateId  = 4;
    localparam int BlkLen   = 128;
    localparam int KeyLen   = 256;
    localparam int CtrLen   = 32;
    localparam int Cmd      = 3;
    localparam int RegW     = 32;
    localparam int StW      = 2 + KeyLen + BlkLen + CtrLen;
    localparam int NumWords = (StW + RegW - 1) / RegW;

    localparam logic [2:0] INS = 3'd1, RES = 3'd2, GEN = 3'd3, UPD = 3'd4, UNI = 3'd5, GENU = 3'd7;

    logic                         clk_i, rst_i, enable_i;
    logic [StateId-1:0]           rd_inst_id_i;
    logic [KeyLen-1:0]            rd_key_o;
    logic [BlkLen-1:0]            rd_v_o;
    logic [CtrLen-1:0]            rd_ctr_o;
    logic                         rd_inst_st_o, rd_fips_o, rd_id_err_o;
    logic                         wr_valid_i, wr_ready_o;
    logic [StateId-1:0]           wr_inst_id_i;
    logic                         wr_fips_i;
    logic [Cmd-1:0]               wr_ccmd_i;
    logic [KeyLen-1:0]            wr_key_i;
    logic [BlkLen-1:0]            wr_v_i;
    logic [CtrLen-1:0]            wr_ctr_i;
    csrng_cmd_sts_e               wr_sts_i, sts_o;
    logic                         sts_ack_o;
    logic [StateId-1:0]           sts_id_o;
    logic                         dump_en_i, dump_id_valid_i, dump_rd_i;
    logic [StateId-1:0]           dump_id_i;
    logic [NApps-1:0]             read_enable_i;
    logic [RegW-1:0]              dump_data_o;
    logic                         dump_last_o;
    logic [NApps-1:0][CtrLen-1:0] reseed_counter_o;

    csrng_state_store dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
        .rd_inst_id_i(rd_inst_id_i), .rd_key_o(rd_key_o), .rd_v_o(rd_v_o), .rd_ctr_o(rd_ctr_o),
        .rd_inst_st_o(rd_inst_st_o), .rd_fips_o(rd_fips_o), .rd_id_err_o(rd_id_err_o),
        .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_inst_id_i(wr_inst_id_i),
        .wr_fips_i(wr_fips_i), .wr_ccmd_i(wr_ccmd_i), .wr_key_i(wr_key_i), .wr_v_i(wr_v_i),
        .wr_ctr_i(wr_ctr_i), .wr_sts_i(wr_sts_i), .sts_ack_o(sts_ack_o), .sts_o(sts_o),
        .sts_id_o(sts_id_o), .dump_en_i(dump_en_i), .dump_id_valid_i(dump_id_valid_i),
        .dump_id_i(dump_id_i), .dump_rd_i(dump_rd_i), .read_enable_i(read_enable_i),
        .dump_data_o(dump_data_o), .dump_last_o(dump_last_o), .reseed_counter_o(reseed_counter_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Reference model: one record per instance plus the expected ack fields.
    logic              m_fips [NApps];
    logic              m_ist  [NApps];
    logic [KeyLen-1:0] m_key  [NApps];
    logic [BlkLen-1:0] m_v    [NApps];
    logic [CtrLen-1:0] m_ctr  [NApps];
    csrng_cmd_sts_e    exp_sts;
    logic [StateId-1:0] exp_id;

    int n_pass, n_total;

    function automatic logic [StW-1:0] m_state(input int id);
        if (id >= NApps) return '0;
        return {m_fips[id], m_ist[id], m_key[id], m_v[id], m_ctr[id]};
    endfunction

    function automatic logic [RegW-1:0] m_word(input int id, input int k);
        logic [NumWords*RegW-1:0] img;
        img = '0;
        img[StW-1:0] = m_state(id);
        return img[k*RegW +: RegW];
    endfunction

    function automatic logic [NApps-1:0][CtrLen-1:0] m_rc();
        logic [NApps-1:0][CtrLen-1:0] r;
        for (int i = 0; i < NApps; i++) r[i] = m_ctr[i];
        return r;
    endfunction

    function automatic void m_zero(input int id);
        m_fips[id] = 1'b0; m_ist[id] = 1'b0; m_key[id] = '0; m_v[id] = '0; m_ctr[id] = '0;
    endfunction

    function automatic void m_apply(input int id, input logic fips, input logic [2:0] ccmd,
                                    input logic [KeyLen-1:0] key, input logic [BlkLen-1:0] v,
                                    input logic [CtrLen-1:0] ctr, input csrng_cmd_sts_e sts);
        if (id < NApps) begin
            if (ccmd == UNI) begin
                m_zero(id);
            end else begin
                m_fips[id] = fips;
                m_ist[id]  = (ccmd == INS) || (ccmd == RES) || (ccmd == GENU) || (ccmd == UPD);
                m_key[id]  = key;
                m_v[id]    = v;
                m_ctr[id]  = ctr;
            end
            exp_sts = sts;
        end else begin
            exp_sts = CMD_STS_INVALID_CMD_SEQ;
        end
        exp_id = StateId'(id);
    endfunction

    function automatic logic [KeyLen-1:0] rkey();
        logic [KeyLen-1:0] r;
        for (int i = 0; i < KeyLen / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [BlkLen-1:0] rblk();
        logic [BlkLen-1:0] r;
        for (int i = 0; i < BlkLen / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_write(input int id, input logic fips, input logic [2:0] ccmd,
                            input logic [KeyLen-1:0] key, input logic [BlkLen-1:0] v,
                            input logic [CtrLen-1:0] ctr, input csrng_cmd_sts_e sts);
        wr_valid_i = 1'b1; wr_inst_id_i = StateId'(id); wr_fips_i = fips; wr_ccmd_i = ccmd;
        wr_key_i = key; wr_v_i = v; wr_ctr_i = ctr; wr_sts_i = sts;
        tick;
        wr_valid_i = 1'b0;
        m_apply(id, fips, ccmd, key, v, ctr, sts);
    endtask

    task automatic test_reset;
        rst_i = 1'b1; enable_i = 1'b0;
        tick; tick;
        n_total++; if (sts_ack_o !== 1'b0) $display("FAIL rst_ack: got %0b want 0", sts_ack_o); else n_pass++;
        n_total++; if (sts_o !== CMD_STS_SUCCESS) $display("FAIL rst_sts: got %0d want %0d", sts_o, CMD_STS_SUCCESS); else n_pass++;
        n_total++; if (sts_id_o !== '0) $display("FAIL rst_sts_id: got %0d want 0", sts_id_o); else n_pass++;
        n_total++; if (wr_ready_o !== 1'b0) $display("FAIL rst_ready: got %0b want 0", wr_ready_o); else n_pass++;
        rst_i = 1'b0; enable_i = 1'b1;
        for (int k = 0; k < NApps; k++) begin
            #1;
            n_total++; if (wr_ready_o !== 1'b0) $display("FAIL clear_ready[%0d]: got %0b want 0", k, wr_ready_o); else n_pass++;
            tick;
        end
        n_total++; if (wr_ready_o !== 1'b1) $display("FAIL active_ready: got %0b want 1", wr_ready_o); else n_pass++;
        n_total++; if (reseed_counter_o !== m_rc()) $display("FAIL rst_reseed: got %h want %h", reseed_counter_o, m_rc()); else n_pass++;
        n_total++; if (sts_ack_o !== 1'b0) $display("FAIL idle_ack: got %0b want 0", sts_ack_o); else n_pass++;
    endtask

    task automatic test_write_read;
        logic [KeyLen-1:0] key;
        key = {8{32'hA5A5A5A5}};
        do_write(2, 1'b1, INS, key, rblk(), 32'd5, CMD_STS_INVALID_GEN_CMD);
        n_total++; if (sts_ack_o !== 1'b1) $display("FAIL wr_ack: got %0b want 1", sts_ack_o); else n_pass++;
        n_total++; if (sts_id_o !== 4'd2) $display("FAIL wr_sts_id: got %0d want 2", sts_id_o); else n_pass++;
        n_total++; if (sts_o !== CMD_STS_INVALID_GEN_CMD) $display("FAIL wr_sts_echo: got %0d want %0d", sts_o, CMD_STS_INVALID_GEN_CMD); else n_pass++;
        rd_inst_id_i = 4'd2;
        #1;
        n_total++; if (rd_inst_st_o !== 1'b1) $display("FAIL rd_inst_st: got %0b want 1", rd_inst_st_o); else n_pass++;
        n_total++; if (rd_ctr_o !== 32'd5) $display("FAIL rd_ctr: got %0d want 5", rd_ctr_o); else n_pass++;
        n_total++; if ({rd_fips_o, rd_inst_st_o, rd_key_o, rd_v_o, rd_ctr_o} !== m_state(2))
            $display("FAIL rd_state2: got %h want %h", {rd_fips_o, rd_inst_st_o, rd_key_o, rd_v_o, rd_ctr_o}, m_state(2)); else n_pass++;
        n_total++; if (reseed_counter_o[2] !== 32'd5) $display("FAIL reseed2: got %0d want 5", reseed_counter_o[2]); else n_pass++;
        tick;
        n_total++; if (sts_ack_o !== 1'b0) $display("FAIL ack_pulse: got %0b want 0", sts_ack_o); else n_pass++;
        n_total++; if (sts_o !== exp_sts) $display("FAIL sts_hold: got %0d want %0d", sts_o, exp_sts); else n_pass++;
    endtask

    task automatic test_uni_bad_id;
        do_write(2, 1'b1, UNI, rkey(), rblk(), $urandom, CMD_STS_SUCCESS);
        n_total++; if (sts_ack_o !== 1'b1 || sts_o !== CMD_STS_SUCCESS) $display("FAIL uni_ack: got %0b/%0d want 1/0", sts_ack_o, sts_o); else n_pass++;
        rd_inst_id_i = 4'd2;
        #1;
        n_total++; if ({rd_fips_o, rd_inst_st_o, rd_key_o, rd_v_o, rd_ctr_o} !== '0)
            $display("FAIL uni_zero: got %h want 0", {rd_fips_o, rd_inst_st_o, rd_key_o, rd_v_o, rd_ctr_o}); else n_pass++;
        do_write(0, 1'b0, RES, rkey(), rblk(), $urandom, CMD_STS_SUCCESS);
        do_write(7, 1'b1, INS, rkey(), rblk(), $urandom, CMD_STS_SUCCESS);
        n_total++; if (sts_o !== CMD_STS_INVALID_CMD_SEQ) $display("FAIL bad_id_sts: got %0d want %0d", sts_o, CMD_STS_INVALID_CMD_SEQ); else n_pass++;
        n_total++; if (sts_id_o !== 4'd7) $display("FAIL bad_id_sts_id: got %0d want 7", sts_id_o); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            rd_inst_id_i = StateId'(i);
            #1;
            n_total++; if ({rd_fips_o, rd_inst_st_o, rd_key_o, rd_v_o, rd_ctr_o} !== m_state(i) || rd_id_err_o !== (i >= NApps))
                $display("FAIL rd_id[%0d]: got %h err %0b want %h err %0b", i,
                         {rd_fips_o, rd_inst_st_o, rd_key_o, rd_v_o, rd_ctr_o}, rd_id_err_o, m_state(i), i >= NApps); else n_pass++;
        end
    endtask

    task automatic test_dump;
        do_write(2, 1'b1, GENU, rkey(), rblk(), $urandom, CMD_STS_SUCCESS);
        dump_en_i = 1'b1; read_enable_i = 4'b0100; dump_id_i = 4'd2; dump_id_valid_i = 1'b1;
        tick;
        dump_id_valid_i = 1'b0; dump_rd_i = 1'b1;
        for (int k = 0; k <= NumWords; k++) begin
            #1;
            n_total++; if (dump_data_o !== m_word(2, k % NumWords))
                $display("FAIL dump_word[%0d]: got %h want %h", k, dump_data_o, m_word(2, k % NumWords)); else n_pass++;
            n_total++; if (dump_last_o !== ((k % NumWords) == NumWords - 1))
                $display("FAIL dump_last[%0d]: got %0b want %0b", k, dump_last_o, (k % NumWords) == NumWords - 1); else n_pass++;
            if ((k % NumWords) == NumWords - 1) begin
                n_total++; if (dump_data_o[RegW-1:2] !== '0) $display("FAIL dump_top_pad: got %h want 0", dump_data_o[RegW-1:2]); else n_pass++;
            end
            tick;
        end
        dump_id_valid_i = 1'b1;
        tick;
        dump_id_valid_i = 1'b0; dump_rd_i = 1'b0;
        #1;
        n_total++; if (dump_data_o !== m_word(2, 0)) $display("FAIL dump_id_beats_rd: got %h want %h", dump_data_o, m_word(2, 0)); else n_pass++;
        read_enable_i = 4'b1011;
        #1;
        n_total++; if (dump_data_o !== '0) $display("FAIL dump_no_perm: got %h want 0", dump_data_o); else n_pass++;
        read_enable_i = 4'b1111; dump_id_i = 4'd5; dump_id_valid_i = 1'b1;
        tick;
        dump_id_valid_i = 1'b0;
        #1;
        n_total++; if (dump_data_o !== '0) $display("FAIL dump_bad_id: got %h want 0", dump_data_o); else n_pass++;
        dump_en_i = 1'b0;
        tick;
    endtask

    task automatic test_back_to_back;
        int id;
        logic v;
        logic [2:0] ccmd;
        logic [KeyLen-1:0] key;
        logic [BlkLen-1:0] blk;
        logic [CtrLen-1:0] ctr;
        logic fips;
        csrng_cmd_sts_e sts;
        for (int n = 0; n < 60; n++) begin
            v = ($urandom_range(0, 3) != 0);
            id = $urandom_range(0, 7); ccmd = 3'($urandom_range(0, 7)); fips = 1'($urandom);
            key = rkey(); blk = rblk(); ctr = $urandom; sts = csrng_cmd_sts_e'($urandom_range(0, 4));
            wr_valid_i = v; wr_inst_id_i = StateId'(id); wr_fips_i = fips; wr_ccmd_i = ccmd;
            wr_key_i = key; wr_v_i = blk; wr_ctr_i = ctr; wr_sts_i = sts;
            tick;
            if (v) m_apply(id, fips, ccmd, key, blk, ctr, sts);
            n_total++; if (sts_ack_o !== v || sts_o !== exp_sts || sts_id_o !== exp_id)
                $display("FAIL b2b_ack[%0d]: got %0b/%0d/%0d want %0b/%0d/%0d", n, sts_ack_o, sts_o, sts_id_o, v, exp_sts, exp_id); else n_pass++;
            id = $urandom_range(0, 7);
            rd_inst_id_i = StateId'(id);
            #1;
            n_total++; if ({rd_fips_o, rd_inst_st_o, rd_key_o, rd_v_o, rd_ctr_o} !== m_state(id) || rd_id_err_o !== (id >= NApps))
                $display("FAIL b2b_rd[%0d]: got %h want %h", n, {rd_fips_o, rd_inst_st_o, rd_key_o, rd_v_o, rd_ctr_o}, m_state(id)); else n_pass++;
            n_total++; if (reseed_counter_o !== m_rc()) $display("FAIL b2b_reseed[%0d]: got %h want %h", n, reseed_counter_o, m_rc()); else n_pass++;
        end
        wr_valid_i = 1'b0;
    endtask

    task automatic test_disable_sweep;
        logic [CtrLen-1:0] ca;
        for (int i = 0; i < NApps; i++) do_write(i, 1'b1, INS, rkey(), rblk(), $urandom | 32'd1, CMD_STS_SUCCESS);
        dump_en_i = 1'b1; read_enable_i = 4'b1111; dump_id_i = 4'd2; dump_id_valid_i = 1'b1;
        wr_valid_i = 1'b1; wr_inst_id_i = 4'd1; wr_fips_i = 1'b0; wr_ccmd_i = UPD;
        wr_key_i = rkey(); wr_v_i = rblk(); wr_ctr_i = 32'd99; wr_sts_i = CMD_STS_SUCCESS;
        enable_i = 1'b0;
        tick;
        dump_id_valid_i = 1'b0;
        m_apply(1, 1'b0, UPD, wr_key_i, wr_v_i, 32'd99, CMD_STS_SUCCESS);
        n_total++; if (sts_ack_o !== 1'b1) $display("FAIL drop_last_ack: got %0b want 1", sts_ack_o); else n_pass++;
        for (int j = 0; j < NApps; j++) begin
            #1;
            n_total++; if (wr_ready_o !== 1'b0) $display("FAIL sweep_ready[%0d]: got %0b want 0", j, wr_ready_o); else n_pass++;
            if (j == 1) enable_i = 1'b1;
            if (j == NApps - 1) wr_valid_i = 1'b0;
            tick;
            m_zero(j);
            n_total++; if (reseed_counter_o !== m_rc() || sts_ack_o !== 1'b0)
                $display("FAIL sweep_step[%0d]: got %h ack %0b want %h ack 0", j, reseed_counter_o, sts_ack_o, m_rc()); else n_pass++;
        end
        n_total++; if (wr_ready_o !== 1'b1) $display("FAIL sweep_reactivate: got %0b want 1", wr_ready_o); else n_pass++;
        for (int i = 0; i < NApps; i++) begin
            rd_inst_id_i = StateId'(i);
            #1;
            n_total++; if ({rd_fips_o, rd_inst_st_o, rd_key_o, rd_v_o, rd_ctr_o} !== '0)
                $display("FAIL sweep_zero[%0d]: got %h want 0", i, {rd_fips_o, rd_inst_st_o, rd_key_o, rd_v_o, rd_ctr_o}); else n_pass++;
        end
        ca = $urandom;
        do_write(0, 1'b0, INS, rkey(), rblk(), ca, CMD_STS_SUCCESS);
        do_write(2, 1'b0, INS, rkey(), rblk(), ~ca, CMD_STS_SUCCESS);
        #1;
        n_total++; if (dump_data_o !== m_word(0, 0)) $display("FAIL dump_id_cleared: got %h want %h", dump_data_o, m_word(0, 0)); else n_pass++;
        dump_en_i = 1'b0;
    endtask

    task automatic test_reset_mid_sweep;
        do_write(3, 1'b0, RES, rkey(), rblk(), $urandom, CMD_STS_INVALID_ACMD);
        n_total++; if (sts_o !== CMD_STS_INVALID_ACMD) $display("FAIL pre_rst_sts: got %0d want %0d", sts_o, CMD_STS_INVALID_ACMD); else n_pass++;
        enable_i = 1'b0;
        tick; tick;
        rst_i = 1'b1;
        tick;
        for (int i = 0; i < NApps; i++) m_zero(i);
        n_total++; if (sts_o !== CMD_STS_SUCCESS || sts_id_o !== '0 || sts_ack_o !== 1'b0)
            $display("FAIL midsweep_rst_sts: got %0d/%0d/%0b want 0/0/0", sts_o, sts_id_o, sts_ack_o); else n_pass++;
        n_total++; if (reseed_counter_o !== m_rc()) $display("FAIL midsweep_rst_reseed: got %h want %h", reseed_counter_o, m_rc()); else n_pass++;
        rst_i = 1'b0; enable_i = 1'b1;
        for (int k = 0; k < NApps; k++) begin
            #1;
            n_total++; if (wr_ready_o !== 1'b0) $display("FAIL restart_ready[%0d]: got %0b want 0", k, wr_ready_o); else n_pass++;
            tick;
        end
        n_total++; if (wr_ready_o !== 1'b1) $display("FAIL restart_active: got %0b want 1", wr_ready_o); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        n_pass = 0; n_total = 0;
        for (int i = 0; i < NApps; i++) m_zero(i);
        exp_sts = CMD_STS_SUCCESS; exp_id = '0;
        rst_i = 1'b1; enable_i = 1'b0; rd_inst_id_i = '0;
        wr_valid_i = 1'b0; wr_inst_id_i = '0; wr_fips_i = 1'b0; wr_ccmd_i = '0;
        wr_key_i = '0; wr_v_i = '0; wr_ctr_i = '0; wr_sts_i = CMD_STS_SUCCESS;
        dump_en_i = 1'b0; dump_id_valid_i = 1'b0; dump_id_i = '0; dump_rd_i = 1'b0;
        read_enable_i = '0;
        test_reset;
        test_write_read;
        test_uni_bad_id;
        test_dump;
        test_back_to_back;
        test_disable_sweep;
        test_reset_mid_sweep;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
